// File: rtl/fpu_pkg.sv
// Shared floating-point constants for the FPU front-end blocks: field widths,
// special values, response flag bit positions and the add sequencer state encoding.
package fpu_pkg;

  localparam int EXP_WIDTH_64      = 11;
  localparam int FRACTION_WIDTH_64 = 52;
  localparam int EXP_WIDTH_32      = 8;
  localparam int FRACTION_WIDTH_32 = 23;

  localparam logic [63:0] NAN_VALUE_64 = 64'hFFF8_0000_0000_0000;
  localparam logic [63:0] INF_VALUE_64 = 64'h7FF0_0000_0000_0000;
  localparam logic [31:0] NAN_VALUE_32 = 32'hFFC0_0000;
  localparam logic [31:0] INF_VALUE_32 = 32'h7F80_0000;

  localparam int FLAG_NAN  = 3;
  localparam int FLAG_OVF  = 2;
  localparam int FLAG_UNF  = 1;
  localparam int FLAG_ZERO = 0;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  function automatic int exp_width(input int float_width);
    return (float_width == 32) ? EXP_WIDTH_32 : EXP_WIDTH_64;
  endfunction

  function automatic int fraction_width(input int float_width);
    return (float_width == 32) ? FRACTION_WIDTH_32 : FRACTION_WIDTH_64;
  endfunction

endpackage

// File: rtl/fpu_req_fifo.sv
// Request FIFO for the add sequencer: power-of-two depth, head visible on rdata,
// pointers wrap naturally modulo DEPTH.
module fpu_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == {CW{1'b0}});
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {CW{1'b0}};
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fpu_add_sequencer.sv
// Front end for the multicycle adder: queues requests, issues one at a time with
// stable operands, detects completion on the rising edge of add_done, returns results.
module fpu_add_sequencer
  import fpu_pkg::*;
#(
  parameter int FLOAT_WIDTH = 64,
  parameter int DEPTH       = 4,
  parameter int TAG_WIDTH   = 4,
  parameter int TIMEOUT     = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_op_sub,
  input  logic [FLOAT_WIDTH-1:0] req_op1,
  input  logic [FLOAT_WIDTH-1:0] req_op2,
  input  logic [TAG_WIDTH-1:0]   req_tag,
  output logic                   add_start,
  output logic                   add_op_sub,
  output logic [FLOAT_WIDTH-1:0] add_op1,
  output logic [FLOAT_WIDTH-1:0] add_op2,
  input  logic [FLOAT_WIDTH-1:0] add_out,
  input  logic                   add_nan,
  input  logic                   add_overflow,
  input  logic                   add_underflow,
  input  logic                   add_zero,
  input  logic                   add_done,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [FLOAT_WIDTH-1:0] rsp_data,
  output logic [3:0]             rsp_flags,
  output logic                   rsp_timeout,
  output logic [TAG_WIDTH-1:0]   rsp_tag
);

  localparam int REQ_W = 1 + TAG_WIDTH + 2 * FLOAT_WIDTH;
  localparam int TW    = $clog2(TIMEOUT);

  logic [1:0]           state;
  logic                 done_q;
  logic [TW-1:0]        timer;
  logic [TAG_WIDTH-1:0] issue_tag;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_pop;
  logic [REQ_W-1:0]     fifo_wdata;
  logic [REQ_W-1:0]     fifo_rdata;
  logic                 completion;

  assign req_ready  = ~fifo_full;
  assign fifo_wdata = {req_op_sub, req_tag, req_op1, req_op2};
  assign fifo_pop   = (state == ST_IDLE) && !fifo_empty;
  // done_q resets high so a done level left over from an aborted operation is never an edge.
  assign completion = add_done & ~done_q;

  fpu_req_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (req_valid & req_ready),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      done_q      <= 1'b1;
      timer       <= {TW{1'b0}};
      issue_tag   <= {TAG_WIDTH{1'b0}};
      add_start   <= 1'b0;
      add_op_sub  <= 1'b0;
      add_op1     <= {FLOAT_WIDTH{1'b0}};
      add_op2     <= {FLOAT_WIDTH{1'b0}};
      rsp_valid   <= 1'b0;
      rsp_data    <= {FLOAT_WIDTH{1'b0}};
      rsp_flags   <= 4'b0000;
      rsp_timeout <= 1'b0;
      rsp_tag     <= {TAG_WIDTH{1'b0}};
    end else begin
      done_q    <= add_done;
      add_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Operands only ever change here, so the adder sees them stable all operation.
          if (!fifo_empty) begin
            {add_op_sub, issue_tag, add_op1, add_op2} <= fifo_rdata;
            add_start <= 1'b1;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          timer <= {TW{1'b0}};
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (completion) begin
            rsp_data            <= add_out;
            rsp_flags[FLAG_NAN] <= add_nan;
            rsp_flags[FLAG_OVF] <= add_overflow;
            rsp_flags[FLAG_UNF] <= add_underflow;
            rsp_flags[FLAG_ZERO] <= add_zero;
            rsp_timeout         <= 1'b0;
            rsp_tag             <= issue_tag;
            rsp_valid           <= 1'b1;
            state               <= ST_RESP;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            rsp_data    <= {FLOAT_WIDTH{1'b0}};
            rsp_flags   <= 4'b0000;
            rsp_timeout <= 1'b1;
            rsp_tag     <= issue_tag;
            rsp_valid   <= 1'b1;
            state       <= ST_RESP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_add_sequencer.sv
// Self-checking bench for fpu_add_sequencer with a behavioural multicycle adder
// (done falls after start, rises 7 cycles after it) behind the block.
module tb_fpu_add_sequencer;

  localparam int TMO = 16;

  typedef struct {
    logic [63:0] op1;
    logic [63:0] op2;
    logic        sub;
    logic [3:0]  tag;
    logic [63:0] exp_data;
    logic [3:0]  exp_flags;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  flags;
    logic [3:0]  tag;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_op_sub = 1'b0;
  logic [63:0] req_op1 = '0;
  logic [63:0] req_op2 = '0;
  logic [3:0]  req_tag = '0;
  logic        add_start;
  logic        add_op_sub;
  logic [63:0] add_op1;
  logic [63:0] add_op2;
  logic [63:0] add_out = '0;
  logic        add_nan = 1'b0;
  logic        add_overflow = 1'b0;
  logic        add_underflow = 1'b0;
  logic        add_zero = 1'b0;
  logic        add_done;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_data;
  logic [3:0]  rsp_flags;
  logic        rsp_timeout;
  logic [3:0]  rsp_tag;

  int   checks = 0;
  int   failures = 0;
  rsp_t exp_q[$];
  vec_t vecs[5];

  logic        done_r = 1'b1;
  int          acnt = 0;
  logic        stuck = 1'b0;
  logic        seen_full;
  logic        have_snap;
  logic [63:0] snap_data;
  logic [3:0]  snap_flags;
  logic [3:0]  snap_tag;
  logic [63:0] ra;
  logic [63:0] rb;
  logic        rs;
  int          n;

  always #5 clk = ~clk;

  fpu_add_sequencer #(
    .FLOAT_WIDTH (64),
    .DEPTH       (4),
    .TAG_WIDTH   (4),
    .TIMEOUT     (TMO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op_sub    (req_op_sub),
    .req_op1       (req_op1),
    .req_op2       (req_op2),
    .req_tag       (req_tag),
    .add_start     (add_start),
    .add_op_sub    (add_op_sub),
    .add_op1       (add_op1),
    .add_op2       (add_op2),
    .add_out       (add_out),
    .add_nan       (add_nan),
    .add_overflow  (add_overflow),
    .add_underflow (add_underflow),
    .add_zero      (add_zero),
    .add_done      (add_done),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_flags     (rsp_flags),
    .rsp_timeout   (rsp_timeout),
    .rsp_tag       (rsp_tag)
  );

  function automatic logic is_nan64(input logic [63:0] v);
    return (v[62:52] == 11'h7FF) && (v[51:0] != 52'd0);
  endfunction

  // IEEE double add/sub via real arithmetic; returns {result, nan, ovf, unf, zero}.
  function automatic logic [67:0] fp_add(input logic [63:0] a, input logic [63:0] b, input logic sub);
    real         r;
    logic [63:0] q;
    if (is_nan64(a) || is_nan64(b)) return {64'hFFF8_0000_0000_0000, 4'b1000};
    r = sub ? ($bitstoreal(a) - $bitstoreal(b)) : ($bitstoreal(a) + $bitstoreal(b));
    q = $realtobits(r);
    if (is_nan64(q)) return {64'hFFF8_0000_0000_0000, 4'b1000};
    if (q[62:0] == 63'd0) return {64'd0, 4'b0001};
    if (q[62:52] == 11'h7FF) return {q, 4'b0100};
    if (q[62:52] == 11'h000) return {q, 4'b0010};
    return {q, 4'b0000};
  endfunction

  function automatic logic [63:0] rnd_op();
    logic [63:0] v;
    v[63]    = 1'($urandom_range(0, 1));
    v[62:52] = 11'($urandom_range(1000, 1046));
    v[51:32] = 20'($urandom);
    v[31:0]  = $urandom;
    return v;
  endfunction

  // Adder stand-in: samples the held operands in its final stage, raises done in T+7.
  assign add_done = stuck | done_r;
  always @(posedge clk) begin
    if (add_start) begin
      acnt   <= 1;
      done_r <= 1'b0;
    end else if (acnt == 6) begin
      acnt   <= 0;
      done_r <= 1'b1;
      {add_out, add_nan, add_overflow, add_underflow, add_zero} <= fp_add(add_op1, add_op2, add_op_sub);
    end else if (acnt != 0) begin
      acnt <= acnt + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_rsp(input string nm, input logic [63:0] d, input logic [3:0] f,
                         input logic [3:0] t, input logic to);
    chk({nm, "_data"}, rsp_data, d);
    chk({nm, "_flags"}, {60'd0, rsp_flags}, {60'd0, f});
    chk({nm, "_tag"}, {60'd0, rsp_tag}, {60'd0, t});
    chk({nm, "_timeout"}, {63'd0, rsp_timeout}, {63'd0, to});
  endtask

  task automatic wait_start(input int lim, output int cnt);
    cnt = 0;
    while (add_start !== 1'b1 && cnt < lim) begin step(); cnt++; end
  endtask

  task automatic wait_rsp(input int lim, output int cnt);
    cnt = 0;
    while (rsp_valid !== 1'b1 && cnt < lim) begin step(); cnt++; end
  endtask

  task automatic push_req(input logic [63:0] a, input logic [63:0] b, input logic s, input logic [3:0] t);
    int   w = 0;
    rsp_t e;
    req_valid = 1'b1; req_op1 = a; req_op2 = b; req_op_sub = s; req_tag = t;
    while (req_ready !== 1'b1 && w < 300) begin step(); w++; end
    chk("req_accept_in_time", {63'd0, (w < 300)}, 64'd1);
    step();
    req_valid = 1'b0;
    {e.data, e.flags} = fp_add(a, b, s);
    e.tag = t;
    exp_q.push_back(e);
  endtask

  task automatic collect(input int cnt, input int lim, input logic rand_ready);
    int   got = 0;
    int   cyc = 0;
    rsp_t e;
    while (got < cnt && cyc < lim) begin
      if (rand_ready) rsp_ready = 1'($urandom_range(0, 1));
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk_rsp("sb", e.data, e.flags, e.tag, 1'b0);
        end
        got++;
      end
      step();
      cyc++;
    end
    rsp_ready = 1'b0;
    chk("rsp_count", 64'(got), 64'(cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b0, 4'd5, 64'h4008_0000_0000_0000, 4'b0000};
    vecs[1] = '{64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b1, 4'd6, 64'h0000_0000_0000_0000, 4'b0001};
    vecs[2] = '{64'h7FF8_0000_0000_0000, 64'h3FF0_0000_0000_0000, 1'b0, 4'd7, 64'hFFF8_0000_0000_0000, 4'b1000};
    vecs[3] = '{64'h4008_0000_0000_0000, 64'h3FF0_0000_0000_0000, 1'b1, 4'd8, 64'h4000_0000_0000_0000, 4'b0000};
    vecs[4] = '{64'hC000_0000_0000_0000, 64'h3FF0_0000_0000_0000, 1'b0, 4'd9, 64'hBFF0_0000_0000_0000, 4'b0000};

    // Reset state
    repeat (3) step();
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_add_start", {63'd0, add_start}, 64'd0);
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk_rsp("rst", 64'd0, 4'd0, 4'd0, 1'b0);
    chk("rst_add_op1", add_op1, 64'd0);
    rst_n = 1'b1;
    step();

    // Directed vectors: latency and result
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_op1 = vecs[i].op1; req_op2 = vecs[i].op2;
      req_op_sub = vecs[i].sub; req_tag = vecs[i].tag;
      step();
      req_valid = 1'b0;
      wait_start(20, n);
      chk("issue_at_R+2", 64'(n + 1), 64'd2);
      chk("issue_op1", add_op1, vecs[i].op1);
      wait_rsp(40, n);
      chk("rsp_at_issue+8", 64'(n), 64'd8);
      chk_rsp("vec", vecs[i].exp_data, vecs[i].exp_flags, vecs[i].tag, 1'b0);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("rsp_valid_drop", {63'd0, rsp_valid}, 64'd0);
    end

    // Burst of 6 with the consumer stalled for 40 cycles
    seen_full = 1'b0;
    have_snap = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) push_req(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 4'(i));
      end
      begin
        for (int c = 0; c < 40; c++) begin
          if (!req_ready) seen_full = 1'b1;
          if (rsp_valid) begin
            if (!have_snap) begin
              have_snap = 1'b1; snap_data = rsp_data; snap_flags = rsp_flags; snap_tag = rsp_tag;
            end else begin
              chk("hold_data", rsp_data, snap_data);
              chk("hold_flags", {60'd0, rsp_flags}, {60'd0, snap_flags});
              chk("hold_tag", {60'd0, rsp_tag}, {60'd0, snap_tag});
            end
          end
          step();
        end
        chk("burst_full_seen", {63'd0, seen_full}, 64'd1);
        chk("burst_ready_low", {63'd0, req_ready}, 64'd0);
        chk("burst_rsp_pending", {63'd0, rsp_valid}, 64'd1);
        rsp_ready = 1'b1;
        collect(6, 400, 1'b0);
      end
    join

    // Randomized traffic with random backpressure
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          repeat ($urandom_range(0, 3)) step();
          ra = rnd_op();
          rb = (i % 5 == 0) ? ra : rnd_op();
          rs = (i % 5 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
          push_req(ra, rb, rs, 4'(i));
        end
      end
      collect(20, 3000, 1'b1);
    join
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    // done stuck high: no false completion, timeout response
    stuck = 1'b1;
    req_valid = 1'b1; req_op1 = 64'h3FF0_0000_0000_0000; req_op2 = 64'h3FF0_0000_0000_0000;
    req_op_sub = 1'b0; req_tag = 4'hA;
    step();
    req_valid = 1'b0;
    wait_start(20, n);
    wait_rsp(60, n);
    chk("timeout_latency", 64'(n), 64'(TMO + 1));
    chk_rsp("tmo", 64'd0, 4'd0, 4'hA, 1'b1);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    stuck = 1'b0;

    // Reset pulse during WAIT with a second request queued
    req_valid = 1'b1; req_op1 = 64'h3FF0_0000_0000_0000; req_op2 = 64'h4000_0000_0000_0000;
    req_op_sub = 1'b0; req_tag = 4'hB;
    step();
    req_tag = 4'hC;
    step();
    req_valid = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("mid_rst_add_start", {63'd0, add_start}, 64'd0);
    chk("mid_rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("mid_rst_add_op1", add_op1, 64'd0);
    chk("mid_rst_add_op2", add_op2, 64'd0);
    chk("mid_rst_add_op_sub", {63'd0, add_op_sub}, 64'd0);
    chk_rsp("mid_rst", 64'd0, 4'd0, 4'd0, 1'b0);
    for (int c = 0; c < 20; c++) begin
      step();
      chk("aborted_no_rsp", {63'd0, rsp_valid}, 64'd0);
      chk("flushed_no_issue", {63'd0, add_start}, 64'd0);
    end
    req_valid = 1'b1; req_op1 = vecs[0].op1; req_op2 = vecs[0].op2;
    req_op_sub = vecs[0].sub; req_tag = 4'hD;
    step();
    req_valid = 1'b0;
    wait_start(20, n);
    chk("post_rst_issue", 64'(n + 1), 64'd2);
    wait_rsp(40, n);
    chk("post_rst_rsp_lat", 64'(n), 64'd8);
    chk_rsp("post_rst", vecs[0].exp_data, vecs[0].exp_flags, 4'hD, 1'b0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
